gpu_instr_loader: RTL and testbench
===================================

GPU_INSTR_LOADER -- requirements
Module: gpu_instr_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: instruction-file entries written.
REQ-002 The block SHALL have parameter BEAT_W, default 24: input beat width; 3 beats SHALL make one 72-bit instruction word.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on posedge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port clear, input, 1: synchronous restart of a load session.
REQ-006 The block SHALL have port in_valid, input, 1: beat present.
REQ-007 The block SHALL have port in_data, input, BEAT_W: beat payload.
REQ-008 The block SHALL have port in_last, input, 1: beat is the final beat of the program.
REQ-009 The block SHALL have port in_ready, output, 1: block accepts a beat.
REQ-010 The block SHALL have port wr_en, output, 1: one-cycle write strobe to the instruction file.
REQ-011 The block SHALL have port wr_addr, output, 3: instruction-file index.
REQ-012 The block SHALL have port wr_data, output, 72: word as {opcode[71:66], operand1[65:33], operand2[32:0]}.
REQ-013 The block SHALL have port instr_count, output, 4: words written this session (0..8).
REQ-014 The block SHALL have port done, output, 1: program fully loaded.
REQ-015 The block SHALL have port err_short, output, 1: in_last arrived mid-word.
REQ-016 The block SHALL have port err_overflow, output, 1: more than DEPTH words offered.
REQ-017 The block SHALL have port err_opcode, output, 1: sticky flag, a written opcode exceeded 27.

Function
REQ-018 A beat SHALL be accepted on a posedge where in_valid && in_ready && !clear.
REQ-019 in_ready SHALL be 1 only in state LOAD and SHALL be 0 whenever clear is 1.
REQ-020 Beat order SHALL be MSB first: beat0 -> [71:48], beat1 -> [47:24], beat2 -> [23:0].
REQ-021 A 2-bit beat counter SHALL count 0,1,2 and wrap to 0 after beat2 is accepted.
REQ-022 wr_en SHALL pulse for exactly one cycle, in the cycle after beat2 is accepted, with wr_addr = instr_count (pre-increment) and wr_data holding the assembled word.
REQ-023 instr_count SHALL increment by 1 in the same cycle wr_en is high.
REQ-024 Latency from beat2 acceptance to wr_en SHALL be 1 cycle; back-to-back words SHALL sustain one beat per cycle with no bubbles.
REQ-025 err_opcode SHALL set in the wr_en cycle if wr_data[71:66] > 27; the word SHALL still be written.
REQ-026 FSM states SHALL be LOAD, DONE and ERROR.
REQ-027 In LOAD, if in_last is accepted with beat2, the block SHALL write the word and go to DONE.
REQ-028 In LOAD, if in_last is accepted with beat0 or beat1, the block SHALL discard the partial word, issue no write, set err_short and go to ERROR.
REQ-029 In LOAD, if beat2 of word index DEPTH-1 is accepted without in_last, the block SHALL write that word, set err_overflow and go to ERROR.
REQ-030 In DONE, done SHALL be 1 and all further beats SHALL be refused.
REQ-031 In ERROR, done SHALL be 0 and all further beats SHALL be refused.
REQ-032 In any state, clear SHALL return the FSM to LOAD and zero the beat counter and instr_count.
REQ-033 clear SHALL also zero done and all error flags, and SHALL suppress a pending wr_en.

Reset
REQ-034 While rst is high, the FSM SHALL be LOAD, the counters SHALL be 0, wr_addr SHALL be 0 and wr_data SHALL be 0.
REQ-035 While rst is high, wr_en, done, err_short, err_overflow, err_opcode and in_ready SHALL all be 0.
REQ-036 rst asserted mid-word or mid-write SHALL discard the partial word and deassert wr_en immediately (asynchronously).
REQ-037 in_ready SHALL rise on the first posedge after rst falls.

Verification
REQ-038 Load 2 words (6 beats, in_last on beat 6, opcodes 5 and 20) -> wr_en at addresses 0 and 1, instr_count=2, done=1, no error flags.
REQ-039 Stream 8 words with in_last on the final beat, valid held high throughout -> 8 writes on consecutive-word cadence, done=1, err_overflow=0.
REQ-040 Stream 8 words with no in_last -> 8 writes, err_overflow=1, in_ready=0.
REQ-041 in_last on beat1 of word 0 -> no wr_en, err_short=1, instr_count=0.
REQ-042 Word with opcode 0x3F -> written at addr 0, err_opcode=1; then clear -> all flags 0, in_ready=1.
REQ-043 rst pulsed after beat1 of word 3 -> outputs return to reset values, and the next load starts at wr_addr=0.

Source files
------------

// File: rtl/gpu_instr_loader.sv
// Instruction loader: packs three BEAT_W beats (MSB first) into one instruction word
// and writes the words in order to a DEPTH-entry instruction file.
module gpu_instr_loader #(
  parameter int DEPTH  = 8,
  parameter int BEAT_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [BEAT_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [2:0]            wr_addr,
  output logic [3*BEAT_W-1:0]   wr_data,
  output logic [3:0]            instr_count,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_overflow,
  output logic                  err_opcode
);

  localparam int WORD_W = 3 * BEAT_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [1:0]          beat_cnt;
  logic [2*BEAT_W-1:0] partial;
  logic                ready_q;
  logic                accept;
  logic                last_beat;
  logic                word_done;
  logic                last_word;
  logic                opcode_bad;
  logic [WORD_W-1:0]   word;

  // ready_q holds in_ready low until the first clock edge after reset is released
  assign in_ready   = (state == LOAD) && ready_q && !clear;
  assign accept     = in_valid && in_ready;
  assign last_beat  = (beat_cnt == 2'd2);
  assign word_done  = accept && last_beat;
  assign last_word  = (instr_count == 4'(DEPTH - 1));
  assign word       = {partial, in_data};
  assign opcode_bad = (word[WORD_W-1 -: 6] > 6'd27);
  assign done       = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = LOAD;
    end else if (state == LOAD && accept && in_last) begin
      next_state = last_beat ? DONE : ERROR;
    end else if (word_done && last_word) begin
      next_state = ERROR;
    end
  end

  // A beat with in_last before beat2 drops the partial word; beat2 always writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q      <= 1'b0;
      beat_cnt     <= 2'd0;
      partial      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= 3'd0;
      wr_data      <= '0;
      instr_count  <= 4'd0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      err_opcode   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      wr_en   <= 1'b0;
      if (clear) begin
        beat_cnt     <= 2'd0;
        partial      <= '0;
        instr_count  <= 4'd0;
        err_short    <= 1'b0;
        err_overflow <= 1'b0;
        err_opcode   <= 1'b0;
      end else if (accept) begin
        if (in_last && !last_beat) begin
          beat_cnt  <= 2'd0;
          err_short <= 1'b1;
        end else if (last_beat) begin
          beat_cnt    <= 2'd0;
          wr_en       <= 1'b1;
          wr_addr     <= instr_count[2:0];
          wr_data     <= word;
          instr_count <= instr_count + 4'd1;
          if (opcode_bad) begin
            err_opcode <= 1'b1;
          end
          if (!in_last && last_word) begin
            err_overflow <= 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + 2'd1;
          partial  <= {partial[BEAT_W-1:0], in_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_instr_loader.sv
// Self-checking bench for gpu_instr_loader: a per-cycle vector table plus
// hand-written streaming, overflow and reset sequences.
module tb_gpu_instr_loader;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [71:0] wr_data;
  logic [3:0]  instr_count;
  logic        done;
  logic        err_short;
  logic        err_overflow;
  logic        err_opcode;

  int checks;
  int errors;

  gpu_instr_loader #(.DEPTH(8), .BEAT_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .instr_count  (instr_count),
    .done         (done),
    .err_short    (err_short),
    .err_overflow (err_overflow),
    .err_opcode   (err_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        valid;
    logic [23:0] data;
    logic        last;
    logic        exp_ready;
    logic        exp_wen;
    logic [2:0]  exp_addr;
    logic [71:0] exp_wdata;
    logic [3:0]  exp_cnt;
    logic        exp_done;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(logic clr, logic valid, logic [23:0] data, logic last,
                                 logic ready, logic wen, logic [2:0] addr, logic [71:0] wdata,
                                 logic [3:0] cnt, logic dn, logic [2:0] err);
    vec_t v;
    v.clr = clr; v.valid = valid; v.data = data; v.last = last;
    v.exp_ready = ready; v.exp_wen = wen; v.exp_addr = addr; v.exp_wdata = wdata;
    v.exp_cnt = cnt; v.exp_done = dn; v.exp_err = err;
    return v;
  endfunction

  // Opcodes 1..8 keep the streamed words below the illegal-opcode threshold
  function automatic logic [71:0] mkWord(int k);
    return {6'(k + 1), 33'(k * 7 + 3), 33'(k * 1000 + 5)};
  endfunction

  task automatic applyStimulus(input logic clr, input logic valid, input logic [23:0] data,
                               input logic last);
    clear    = clr;
    in_valid = valid;
    in_data  = data;
    in_last  = last;
  endtask

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doClear();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic streamWords(input int n, input bit with_last, input string tag);
    logic [71:0] w;
    for (int k = 0; k < n; k++) begin
      w = mkWord(k);
      for (int b = 0; b < 3; b++) begin
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, w[71 - 24 * b -: 24], with_last && (k == n - 1) && (b == 2));
        #1;
        checkOutput($sformatf("%s_ready_w%0d_b%0d", tag, k, b), 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        if (b == 2) begin
          checkOutput($sformatf("%s_wen_w%0d", tag, k), 72'(wr_en), 72'd1);
          checkOutput($sformatf("%s_addr_w%0d", tag, k), 72'(wr_addr), 72'(k));
          checkOutput($sformatf("%s_data_w%0d", tag, k), wr_data, w);
          checkOutput($sformatf("%s_cnt_w%0d", tag, k), 72'(instr_count), 72'(k + 1));
        end else begin
          checkOutput($sformatf("%s_nowen_w%0d_b%0d", tag, k, b), 72'(wr_en), 72'd0);
        end
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ready"}, 72'(in_ready), 72'd0);
    checkOutput({tag, "_wen"}, 72'(wr_en), 72'd0);
    checkOutput({tag, "_addr"}, 72'(wr_addr), 72'd0);
    checkOutput({tag, "_data"}, wr_data, 72'd0);
    checkOutput({tag, "_cnt"}, 72'(instr_count), 72'd0);
    checkOutput({tag, "_done"}, 72'(done), 72'd0);
    checkOutput({tag, "_errs"}, 72'({err_short, err_overflow, err_opcode}), 72'd0);
  endtask

  initial begin
    logic [71:0] w;
    logic [71:0] w0;
    logic [71:0] w1;
    logic [71:0] w2;
    checks = 0;
    errors = 0;
    w0 = 72'h14_3456_789A_BCDE_F012;
    w1 = 72'h51_2233_4455_6677_8899;
    w2 = 72'hFC_0000_0000_0000_0001;

    // clr valid data last | ready wen addr wdata cnt done {short,ovf,opc}
    vecs.push_back(mkVec(0, 0, 24'h000000, 0, 0, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h143456, 0, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h789ABC, 0, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'hDEF012, 0, 1, 1, 3'd0, w0,    4'd1, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h512233, 0, 1, 0, 3'd0, 72'h0, 4'd1, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h445566, 0, 1, 0, 3'd0, 72'h0, 4'd1, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h778899, 1, 1, 1, 3'd1, w1,    4'd2, 1, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'hAAAAAA, 0, 0, 0, 3'd0, 72'h0, 4'd2, 1, 3'b000));
    vecs.push_back(mkVec(1, 1, 24'hBBBBBB, 0, 0, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h111111, 0, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h222222, 1, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b100));
    vecs.push_back(mkVec(0, 1, 24'h333333, 0, 0, 0, 3'd0, 72'h0, 4'd0, 0, 3'b100));
    vecs.push_back(mkVec(1, 0, 24'h000000, 0, 0, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'hFC0000, 0, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h000000, 0, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 1, 24'h000001, 0, 1, 1, 3'd0, w2,    4'd1, 0, 3'b001));
    vecs.push_back(mkVec(1, 0, 24'h000000, 0, 0, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));
    vecs.push_back(mkVec(0, 0, 24'h000000, 0, 1, 0, 3'd0, 72'h0, 4'd0, 0, 3'b000));

    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      applyStimulus(vecs[i].clr, vecs[i].valid, vecs[i].data, vecs[i].last);
      #1;
      checkOutput($sformatf("vec%0d_ready", i), 72'(in_ready), 72'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_wen", i), 72'(wr_en), 72'(vecs[i].exp_wen));
      checkOutput($sformatf("vec%0d_cnt", i), 72'(instr_count), 72'(vecs[i].exp_cnt));
      checkOutput($sformatf("vec%0d_done", i), 72'(done), 72'(vecs[i].exp_done));
      checkOutput($sformatf("vec%0d_errs", i), 72'({err_short, err_overflow, err_opcode}),
                  72'(vecs[i].exp_err));
      if (vecs[i].exp_wen) begin
        checkOutput($sformatf("vec%0d_addr", i), 72'(wr_addr), 72'(vecs[i].exp_addr));
        checkOutput($sformatf("vec%0d_data", i), wr_data, vecs[i].exp_wdata);
      end
    end

    // Eight words with in_last on the final beat
    doClear();
    streamWords(8, 1'b1, "s8last");
    #1;
    checkOutput("s8last_done", 72'(done), 72'd1);
    checkOutput("s8last_ovf", 72'(err_overflow), 72'd0);
    checkOutput("s8last_ready", 72'(in_ready), 72'd0);

    // Eight words without in_last overflow the file
    doClear();
    streamWords(8, 1'b0, "s8nolast");
    #1;
    checkOutput("s8nolast_ovf", 72'(err_overflow), 72'd1);
    checkOutput("s8nolast_ready", 72'(in_ready), 72'd0);
    checkOutput("s8nolast_done", 72'(done), 72'd0);
    checkOutput("s8nolast_cnt", 72'(instr_count), 72'd8);

    // Reset after beat1 of word 3, then restart from address 0
    doClear();
    streamWords(3, 1'b0, "pre");
    w = mkWord(3);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, w[71 - 24 * b -: 24], 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_ready_low", 72'(in_ready), 72'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_ready_high", 72'(in_ready), 72'd1);
    streamWords(1, 1'b1, "post");

    // Reset landing inside a write cycle drops wr_en at once
    doClear();
    w = mkWord(0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, w[71 - 24 * b -: 24], 1'b0);
      @(posedge clk);
    end
    #1;
    checkOutput("wrrst_wen_before", 72'(wr_en), 72'd1);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("wrrst_wen_async", 72'(wr_en), 72'd0);
    checkOutput("wrrst_cnt", 72'(instr_count), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
